valu_sequencer: RTL and testbench

- Sequences the combinational vector-lane ALU over a whole vector instruction, one element per cycle.
- Accepts a decoded vector command and reads element pairs from the vector register file (VRF), then drives the ALU operand and control inputs and writes results back.
- For compare ops it collects per-element predicates into a mask instead of writing back.
- Sits between the instruction decoder and the ALU/VRF in each coprocessor lane.

---
 rtl/valu_pkg.sv | 51 +++++
 rtl/valu_op_decode.sv | 42 ++++
 rtl/valu_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_valu_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/valu_pkg.sv
// Purpose : shared types and encodings for the vector-lane ALU sequencer.
// Contents: op codes, sequencer states, ALU output/bitwise/compare selects.
// Users   : valu_op_decode, valu_sequencer.
package valu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_FADD  = 4'd2,
      OP_FSUB  = 4'd3,
      OP_MUL   = 4'd4,
      OP_FMUL  = 4'd5,
      OP_AND   = 4'd6,
      OP_OR    = 4'd7,
      OP_XOR   = 4'd8,
      OP_NOT   = 4'd9,
      OP_CMP0  = 4'd10,
      OP_CMP1  = 4'd11,
      OP_CMP2  = 4'd12,
      OP_CMP3  = 4'd13,
      OP_ILL14 = 4'd14,
      OP_ILL15 = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   // ALU output select
   localparam logic [2:0] OUT_ADDSUB  = 3'b000;
   localparam logic [2:0] OUT_FADDSUB = 3'b001;
   localparam logic [2:0] OUT_MUL     = 3'b010;
   localparam logic [2:0] OUT_FMUL    = 3'b011;
   localparam logic [2:0] OUT_BITWISE = 3'b100;

   // ALU bitwise select
   localparam logic [1:0] BW_AND = 2'd0;
   localparam logic [1:0] BW_OR  = 2'd1;
   localparam logic [1:0] BW_XOR = 2'd2;
   localparam logic [1:0] BW_NOT = 2'd3;

   // ALU compare select
   localparam logic [1:0] CMP_SEL0 = 2'd0;
   localparam logic [1:0] CMP_SEL1 = 2'd1;
   localparam logic [1:0] CMP_SEL2 = 2'd2;
   localparam logic [1:0] CMP_SEL3 = 2'd3;

endpackage

// File: rtl/valu_op_decode.sv
// Purpose : op code -> ALU control decode, flags compare and illegal ops.
// Latency : combinational.
// Ports   : i_op in; o_addsub/o_out_ctrl/o_bitwise_ctrl/o_comp_ctrl/o_is_cmp/o_illegal out.
module valu_op_decode
   import valu_pkg::*;
(
   input  logic [3:0] i_op,
   output logic       o_addsub,
   output logic [2:0] o_out_ctrl,
   output logic [1:0] o_bitwise_ctrl,
   output logic [1:0] o_comp_ctrl,
   output logic       o_is_cmp,
   output logic       o_illegal
);

   always_comb begin
      o_addsub       = 1'b0;
      o_out_ctrl     = OUT_ADDSUB;
      o_bitwise_ctrl = BW_AND;
      o_comp_ctrl    = CMP_SEL0;
      o_is_cmp       = 1'b0;
      o_illegal      = 1'b0;
      case (op_e'(i_op))
         OP_ADD:  o_out_ctrl = OUT_ADDSUB;
         OP_SUB:  begin o_out_ctrl = OUT_ADDSUB;  o_addsub = 1'b1; end
         OP_FADD: o_out_ctrl = OUT_FADDSUB;
         OP_FSUB: begin o_out_ctrl = OUT_FADDSUB; o_addsub = 1'b1; end
         OP_MUL:  o_out_ctrl = OUT_MUL;
         OP_FMUL: o_out_ctrl = OUT_FMUL;
         OP_AND:  begin o_out_ctrl = OUT_BITWISE; o_bitwise_ctrl = BW_AND; end
         OP_OR:   begin o_out_ctrl = OUT_BITWISE; o_bitwise_ctrl = BW_OR;  end
         OP_XOR:  begin o_out_ctrl = OUT_BITWISE; o_bitwise_ctrl = BW_XOR; end
         OP_NOT:  begin o_out_ctrl = OUT_BITWISE; o_bitwise_ctrl = BW_NOT; end
         OP_CMP0: begin o_is_cmp = 1'b1; o_comp_ctrl = CMP_SEL0; end
         OP_CMP1: begin o_is_cmp = 1'b1; o_comp_ctrl = CMP_SEL1; end
         OP_CMP2: begin o_is_cmp = 1'b1; o_comp_ctrl = CMP_SEL2; end
         OP_CMP3: begin o_is_cmp = 1'b1; o_comp_ctrl = CMP_SEL3; end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/valu_sequencer.sv
// Purpose : steps the lane ALU through a vector command, one element per cycle,
//           writing results back to the VRF or collecting compare predicates.
// Latency : vl+2 cycles from command acceptance to done (1 cycle for vl==0 / illegal op).
// Backpr. : cmd_ready only in IDLE; no backpressure from VRF or ALU.
// Ports   : cmd_* (command in), rf_rd_* (VRF read), alu_* (ALU drive/return),
//           wb_* (VRF write), pred_valid/pred_mask, done, err.
module valu_sequencer
   import valu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int VLEN_MAX = 32,
   parameter int IDX_W    = 5,
   parameter int REG_W    = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [3:0]             cmd_op,
   input  logic [REG_W-1:0]       cmd_vd,
   input  logic [REG_W-1:0]       cmd_vs1,
   input  logic [REG_W-1:0]       cmd_vs2,
   input  logic                   cmd_use_scalar,
   input  logic [WIDTH-1:0]       cmd_scalar,
   input  logic [IDX_W:0]         cmd_vl,
   input  logic                   cmd_masked,
   input  logic [VLEN_MAX-1:0]    cmd_mask,
   output logic                   rf_rd_en,
   output logic [REG_W+IDX_W-1:0] rf_rd_addr1,
   output logic [REG_W+IDX_W-1:0] rf_rd_addr2,
   input  logic [WIDTH-1:0]       rf_rd_data1,
   input  logic [WIDTH-1:0]       rf_rd_data2,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic [WIDTH-1:0]       alu_c,
   output logic                   alu_addsub,
   output logic                   alu_mux_ctrl,
   output logic [2:0]             alu_out_ctrl,
   output logic [1:0]             alu_bitwise_ctrl,
   output logic [1:0]             alu_comp_ctrl,
   input  logic [WIDTH-1:0]       alu_result,
   input  logic                   alu_predicate,
   output logic                   wb_en,
   output logic [REG_W+IDX_W-1:0] wb_addr,
   output logic [WIDTH-1:0]       wb_data,
   output logic                   pred_valid,
   output logic [VLEN_MAX-1:0]    pred_mask,
   output logic                   done,
   output logic                   err
);

   localparam logic [IDX_W:0] VL_MAX_C = (IDX_W+1)'(VLEN_MAX);

   seq_state_e             r_state;
   logic [3:0]             r_op;
   logic [REG_W-1:0]       r_vd, r_vs1, r_vs2;
   logic                   r_use_scalar;
   logic [WIDTH-1:0]       r_scalar;
   logic [IDX_W:0]         r_vl;
   logic [IDX_W:0]         r_idx;      // one bit wider so vl==VLEN_MAX is representable
   logic                   r_masked;
   logic [VLEN_MAX-1:0]    r_mask;

   // EXEC stage: element whose VRF data is on rf_rd_data* this cycle
   logic                   r_ex_vld;
   logic [IDX_W-1:0]       r_ex_idx;
   logic                   r_ex_en;

   logic                   r_wb_en;
   logic [REG_W+IDX_W-1:0] r_wb_addr;
   logic [WIDTH-1:0]       r_wb_data;
   logic [VLEN_MAX-1:0]    r_pred_mask;

   logic [3:0]             w_dec_op;
   logic                   w_is_cmp, w_illegal;
   logic [IDX_W:0]         w_vl_clamped;
   logic                   w_accept;
   logic                   w_issue_en;

   // In IDLE the decoder looks at the incoming op so illegality is known at
   // acceptance; otherwise it decodes the latched op for the whole command.
   assign w_dec_op = (r_state == ST_IDLE) ? cmd_op : r_op;

   valu_op_decode u_dec (
      .i_op           (w_dec_op),
      .o_addsub       (alu_addsub),
      .o_out_ctrl     (alu_out_ctrl),
      .o_bitwise_ctrl (alu_bitwise_ctrl),
      .o_comp_ctrl    (alu_comp_ctrl),
      .o_is_cmp       (w_is_cmp),
      .o_illegal      (w_illegal)
   );

   assign w_vl_clamped = (cmd_vl > VL_MAX_C) ? VL_MAX_C : cmd_vl;
   assign w_accept     = (r_state == ST_IDLE) && cmd_valid;
   assign w_issue_en   = !r_masked || r_mask[r_idx[IDX_W-1:0]];

   assign cmd_ready    = (r_state == ST_IDLE);
   assign rf_rd_en     = (r_state == ST_RUN);
   assign rf_rd_addr1  = {r_vs1, r_idx[IDX_W-1:0]};
   assign rf_rd_addr2  = {r_vs2, r_idx[IDX_W-1:0]};

   assign alu_a        = rf_rd_data1;
   assign alu_b        = rf_rd_data2;
   assign alu_c        = r_scalar;
   assign alu_mux_ctrl = r_use_scalar;

   assign wb_en        = r_wb_en;
   assign wb_addr      = r_wb_addr;
   assign wb_data      = r_wb_data;
   assign pred_mask    = r_pred_mask;
   assign done         = (r_state == ST_DONE);
   assign err          = (r_state == ST_DONE) && w_illegal;
   assign pred_valid   = (r_state == ST_DONE) && w_is_cmp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_op         <= '0;
         r_vd         <= '0;
         r_vs1        <= '0;
         r_vs2        <= '0;
         r_use_scalar <= 1'b0;
         r_scalar     <= '0;
         r_vl         <= '0;
         r_idx        <= '0;
         r_masked     <= 1'b0;
         r_mask       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_op         <= cmd_op;
                  r_vd         <= cmd_vd;
                  r_vs1        <= cmd_vs1;
                  r_vs2        <= cmd_vs2;
                  r_use_scalar <= cmd_use_scalar;
                  r_scalar     <= cmd_scalar;
                  r_vl         <= w_vl_clamped;
                  r_idx        <= '0;
                  r_masked     <= cmd_masked;
                  r_mask       <= cmd_mask;
                  r_state      <= (w_vl_clamped == '0 || w_illegal) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               r_idx <= r_idx + 1'b1;
               if (r_idx == r_vl - 1'b1) r_state <= ST_DRAIN;
            end
            ST_DRAIN: r_state <= ST_DONE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // Issue -> EXEC -> writeback pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_vld  <= 1'b0;
         r_ex_idx  <= '0;
         r_ex_en   <= 1'b0;
         r_wb_en   <= 1'b0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
      end else begin
         r_ex_vld  <= (r_state == ST_RUN);
         r_ex_idx  <= r_idx[IDX_W-1:0];
         r_ex_en   <= w_issue_en;
         r_wb_en   <= r_ex_vld && r_ex_en && !w_is_cmp;
         r_wb_addr <= {r_vd, r_ex_idx};
         r_wb_data <= alu_result;
      end
   end

   // Cleared on acceptance so bits >= vl and masked-off bits stay 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pred_mask <= '0;
      end else if (w_accept) begin
         r_pred_mask <= '0;
      end else if (r_ex_vld && w_is_cmp) begin
         r_pred_mask[r_ex_idx] <= r_ex_en && alu_predicate;
      end
   end

endmodule

// File: tb/tb_valu_sequencer.sv
// Purpose : self-checking bench for valu_sequencer with a VRF model, an ALU stub
//           and an op-level reference model; directed cases then random commands.
module tb_valu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic [4:0]  cmd_vd = '0, cmd_vs1 = '0, cmd_vs2 = '0;
   logic        cmd_use_scalar = 1'b0;
   logic [31:0] cmd_scalar = '0;
   logic [5:0]  cmd_vl = '0;
   logic        cmd_masked = 1'b0;
   logic [31:0] cmd_mask = '0;
   logic        rf_rd_en;
   logic [9:0]  rf_rd_addr1, rf_rd_addr2;
   logic [31:0] rf_rd_data1 = '0, rf_rd_data2 = '0;
   logic [31:0] alu_a, alu_b, alu_c;
   logic        alu_addsub, alu_mux_ctrl;
   logic [2:0]  alu_out_ctrl;
   logic [1:0]  alu_bitwise_ctrl, alu_comp_ctrl;
   logic [31:0] alu_result;
   logic        alu_predicate;
   logic        wb_en;
   logic [9:0]  wb_addr;
   logic [31:0] wb_data;
   logic        pred_valid;
   logic [31:0] pred_mask;
   logic        done, err;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] vrf [32][32];
   logic [9:0]  last_wb_addr;
   logic [31:0] last_pred;

   always #5 clk = ~clk;

   valu_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2),
      .cmd_use_scalar(cmd_use_scalar), .cmd_scalar(cmd_scalar), .cmd_vl(cmd_vl),
      .cmd_masked(cmd_masked), .cmd_mask(cmd_mask),
      .rf_rd_en(rf_rd_en), .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
      .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
      .alu_addsub(alu_addsub), .alu_mux_ctrl(alu_mux_ctrl), .alu_out_ctrl(alu_out_ctrl),
      .alu_bitwise_ctrl(alu_bitwise_ctrl), .alu_comp_ctrl(alu_comp_ctrl),
      .alu_result(alu_result), .alu_predicate(alu_predicate),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .pred_valid(pred_valid), .pred_mask(pred_mask), .done(done), .err(err)
   );

   // VRF read port, 1-cycle latency
   always @(posedge clk) begin
      if (rf_rd_en) begin
         rf_rd_data1 <= vrf[rf_rd_addr1[9:5]][rf_rd_addr1[4:0]];
         rf_rd_data2 <= vrf[rf_rd_addr2[9:5]][rf_rd_addr2[4:0]];
      end
   end

   // ALU stub driven purely by the control lines; "float" variants are
   // distinguished by a fixed XOR so a wrong output select shows up.
   logic [31:0] bop;
   always_comb begin
      bop = alu_mux_ctrl ? alu_c : alu_b;
      alu_result = '0;
      case (alu_out_ctrl)
         3'b000:  alu_result = alu_addsub ? alu_a - bop : alu_a + bop;
         3'b001:  alu_result = (alu_addsub ? alu_a - bop : alu_a + bop) ^ 32'hF000_0000;
         3'b010:  alu_result = alu_a * bop;
         3'b011:  alu_result = (alu_a * bop) ^ 32'h0F00_0000;
         3'b100:  case (alu_bitwise_ctrl)
                     2'd0:    alu_result = alu_a & bop;
                     2'd1:    alu_result = alu_a | bop;
                     2'd2:    alu_result = alu_a ^ bop;
                     default: alu_result = ~alu_a;
                  endcase
         default: alu_result = '0;
      endcase
      case (alu_comp_ctrl)
         2'd0:    alu_predicate = (alu_a == bop);
         2'd1:    alu_predicate = (alu_a != bop);
         2'd2:    alu_predicate = (alu_a <  bop);
         default: alu_predicate = (alu_a >= bop);
      endcase
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Op-level reference: what each op code means for one element pair.
   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         0:       return a + b;
         1:       return a - b;
         2:       return (a + b) ^ 32'hF000_0000;
         3:       return (a - b) ^ 32'hF000_0000;
         4:       return a * b;
         5:       return (a * b) ^ 32'h0F00_0000;
         6:       return a & b;
         7:       return a | b;
         8:       return a ^ b;
         9:       return ~a;
         default: return '0;
      endcase
   endfunction

   function automatic logic ref_pred(input int op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         10:      return a == b;
         11:      return a != b;
         12:      return a < b;
         default: return a >= b;
      endcase
   endfunction

   function automatic logic [2:0] ref_out(input int op);
      case (op)
         0, 1:    return 3'b000;
         2, 3:    return 3'b001;
         4:       return 3'b010;
         5:       return 3'b011;
         default: return 3'b100;
      endcase
   endfunction

   task automatic run_cmd(input int op, input logic [4:0] vd, input logic [4:0] vs1,
                          input logic [4:0] vs2, input logic us, input logic [31:0] sc,
                          input int vl, input logic msk, input logic [31:0] mask);
      logic [41:0] exp_q [$];
      logic [41:0] e;
      logic [31:0] a, b, exp_pred;
      logic [4:0]  kk;
      int vlc, exp_cyc, reads;
      bit ill, cmp, en, got_done;

      vlc = (vl > 32) ? 32 : vl;
      ill = (op >= 14);
      cmp = (op >= 10) && (op <= 13);
      exp_pred = '0;
      if (!ill) begin
         for (int k = 0; k < vlc; k++) begin
            kk = k[4:0];
            a  = vrf[vs1][k];
            b  = us ? sc : vrf[vs2][k];
            en = !msk || mask[k];
            if (cmp) exp_pred[k] = en && ref_pred(op, a, b);
            else if (en) exp_q.push_back({vd, kk, ref_alu(op, a, b)});
         end
      end
      exp_cyc = (ill || vlc == 0) ? 1 : vlc + 2;

      @(negedge clk);
      check_eq("ready_idle", cmd_ready, 1);
      cmd_op = op[3:0]; cmd_vd = vd; cmd_vs1 = vs1; cmd_vs2 = vs2;
      cmd_use_scalar = us; cmd_scalar = sc; cmd_vl = vl[5:0];
      cmd_masked = msk; cmd_mask = mask; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      check_eq("ready_busy", cmd_ready, 0);

      reads = 0;
      got_done = 0;
      for (int n = 1; n <= vlc + 8 && !got_done; n++) begin
         @(negedge clk);
         if (rf_rd_en) reads++;
         if (wb_en) begin
            if (exp_q.size() == 0) begin
               check_eq("wb_extra", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("wb_addr", wb_addr, e[41:32]);
               check_eq("wb_data", wb_data, e[31:0]);
               check_eq("out_ctrl", alu_out_ctrl, ref_out(op));
               check_eq("mux_ctrl", alu_mux_ctrl, us);
            end
            vrf[wb_addr[9:5]][wb_addr[4:0]] = wb_data;
            last_wb_addr = wb_addr;
         end
         if (done) begin
            got_done = 1;
            check_eq("done_cycle", n, exp_cyc);
            check_eq("err", err, ill);
            check_eq("pred_valid", pred_valid, cmp);
            if (cmp) begin
               check_eq("pred_mask", pred_mask, exp_pred);
               last_pred = pred_mask;
            end
         end
      end
      if (!got_done) check_eq("done_timeout", 0, 1);
      check_eq("wb_missing", exp_q.size(), 0);
      check_eq("read_count", reads, ill ? 0 : vlc);

      @(negedge clk);
      check_eq("ready_after", cmd_ready, 1);
      check_eq("done_after", done, 0);
      check_eq("wb_after", wb_en, 0);
      if (cmp) check_eq("pred_hold", pred_mask, exp_pred);
   endtask

   initial begin
      bit found;

      for (int r = 0; r < 32; r++)
         for (int k = 0; k < 32; k++)
            vrf[r][k] = $urandom;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ready", cmd_ready, 1);
      check_eq("rst_rd_en", rf_rd_en, 0);
      check_eq("rst_wb_en", wb_en, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_pred_valid", pred_valid, 0);
      check_eq("rst_pred_mask", pred_mask, 0);
      rst_n = 1'b1;

      // ADD r1+r2 -> r3
      for (int k = 0; k < 4; k++) begin
         vrf[1][k] = 32'(k + 1);
         vrf[2][k] = 32'(10 * (k + 1));
      end
      run_cmd(0, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0, 4, 1'b0, 32'h0);
      check_eq("add_r3_0", vrf[3][0], 32'd11);
      check_eq("add_r3_3", vrf[3][3], 32'd44);

      // SUB scalar, masked 3'b101
      for (int k = 0; k < 3; k++) vrf[6][k] = 32'd9;
      vrf[7][1] = 32'hDEAD_BEEF;
      run_cmd(1, 5'd7, 5'd6, 5'd2, 1'b1, 32'd5, 3, 1'b1, 32'h5);
      check_eq("sub_idx0", vrf[7][0], 32'd4);
      check_eq("sub_idx1_kept", vrf[7][1], 32'hDEAD_BEEF);
      check_eq("sub_idx2", vrf[7][2], 32'd4);

      // CMP eq over full length, equal at even indices
      for (int k = 0; k < 32; k++) begin
         vrf[4][k] = 32'(k);
         vrf[5][k] = (k % 2 == 0) ? 32'(k) : 32'(k + 100);
      end
      run_cmd(10, 5'd9, 5'd4, 5'd5, 1'b0, 32'd0, 32, 1'b0, 32'h0);
      check_eq("cmp_even", last_pred, 32'h5555_5555);

      // vl==0, illegal op, vl==0 compare
      run_cmd(0, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0, 0, 1'b0, 32'h0);
      run_cmd(15, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0, 4, 1'b0, 32'h0);
      run_cmd(14, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0, 0, 1'b0, 32'h0);
      run_cmd(11, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0, 0, 1'b0, 32'h0);

      // FMUL clamped from 40 to 32 elements
      run_cmd(5, 5'd10, 5'd11, 5'd12, 1'b0, 32'd0, 40, 1'b0, 32'h0);
      check_eq("clamp_last_addr", last_wb_addr, {5'd10, 5'd31});

      // Asynchronous reset during RUN at idx 2 of vl=8
      @(negedge clk);
      cmd_op = 4'd0; cmd_vd = 5'd20; cmd_vs1 = 5'd1; cmd_vs2 = 5'd2;
      cmd_use_scalar = 1'b0; cmd_vl = 6'd8; cmd_masked = 1'b0; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      found = 0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if (wb_en) vrf[wb_addr[9:5]][wb_addr[4:0]] = wb_data;
         if (rf_rd_en && rf_rd_addr1[4:0] == 5'd2) found = 1;
      end
      check_eq("rst_reach_idx2", found, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_rd_en", rf_rd_en, 0);
      check_eq("arst_wb_en", wb_en, 0);
      check_eq("arst_ready", cmd_ready, 1);
      check_eq("arst_done", done, 0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check_eq("arst_hold_wb", wb_en, 0);
         check_eq("arst_hold_rd", rf_rd_en, 0);
      end
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check_eq("post_rst_wb", wb_en, 0);
      end
      run_cmd(0, 5'd21, 5'd1, 5'd2, 1'b0, 32'd0, 8, 1'b0, 32'h0);

      // vd == vs1 in place update
      run_cmd(8, 5'd13, 5'd13, 5'd14, 1'b0, 32'd0, 16, 1'b0, 32'h0);

      // Random commands
      for (int t = 0; t < 60; t++) begin
         int op, vl;
         op = $urandom_range(0, 15);
         vl = ($urandom_range(0, 7) == 0) ? 32 : $urandom_range(0, 40);
         run_cmd(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                 vl, 1'($urandom_range(0, 1)), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
